// File: rtl/flb_sdm_mash_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : flb_sdm_mash_if
// Purpose  : Bundle of the FLB sigma-delta modulator control/data signals.
//            master = producer of the fractional word and CSR controls,
//            slave  = the modulator, which returns the modulated sample.
// Signals  : s_os                 W-bit unsigned fractional offset
//            csr_flb_sdm_en       run enable (low clears all state)
//            csr_flb_sdm_order    01/00 = order 1, 10 = order 2, 11 = order 3
//            csr_flb_sdm_thrm_en  thermometer output enable
//            os_bin               signed 4-bit modulator output y (-3..+4)
//            os_thrm              thermometer code of y+3, LSB-first ones
//            os_vld               os_bin/os_thrm carry a valid sample
// Revision : 1.0 - initial release
// ============================================================================
interface flb_sdm_mash_if #(
    parameter int W = 8
);
    logic [W-1:0] s_os;
    logic         csr_flb_sdm_en;
    logic [1:0]   csr_flb_sdm_order;
    logic         csr_flb_sdm_thrm_en;
    logic [3:0]   os_bin;
    logic [6:0]   os_thrm;
    logic         os_vld;

    modport master (
        output s_os, csr_flb_sdm_en, csr_flb_sdm_order, csr_flb_sdm_thrm_en,
        input  os_bin, os_thrm, os_vld
    );

    modport slave (
        input  s_os, csr_flb_sdm_en, csr_flb_sdm_order, csr_flb_sdm_thrm_en,
        output os_bin, os_thrm, os_vld
    );
endinterface
`default_nettype wire

// File: rtl/flb_sdm_mash.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : flb_sdm_mash
// Purpose  : Parametrised MASH 1-1-1 sigma-delta modulator for the FLB
//            fractional path. Turns a W-bit unsigned offset into a multi-level
//            integer sequence whose long-term mean is s_os/2^W, with run-time
//            selectable order 1/2/3. Output as signed binary and thermometer.
// Ports    : nsh_clk    clock, rising edge
//            nsh_rst_n  asynchronous active-low reset
//            bus        flb_sdm_mash_if.slave (s_os, csr_* in; os_* out)
// Options  : FLB_SDM_DITHER_EN - adds a 16-bit LFSR whose LSB dithers the
//            first accumulator (mean then holds within +/-1/2^W).
// Revision : 1.0 - initial release
// ============================================================================
module flb_sdm_mash #(
    parameter int W = 8
) (
    input  wire              nsh_clk,
    input  wire              nsh_rst_n,
    flb_sdm_mash_if.slave    bus
);

    localparam logic [1:0]  c_ORD1      = 2'b01;
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0] r_acc1, r_acc2, r_acc3;
    logic         r_c2_d, r_c3_d, r_c3_dd;
    logic         r_run;          // previous edge was an enabled update
    logic [1:0]   r_order;        // order in use (00 already folded to 01)
    logic [3:0]   r_os_bin;
    logic [6:0]   r_os_thrm;
    logic         r_os_vld;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [1:0]   w_order;
    logic         w_ord2p, w_ord3, w_restart, w_d;
    logic [W:0]   w_s1, w_s2, w_s3;
    logic         w_c2, w_c3;
    logic [3:0]   w_y, w_lvl;
    logic [6:0]   w_thrm;

    // Order 00 behaves as order 1, so 00 <-> 01 is not an order change.
    assign w_order = (bus.csr_flb_sdm_order == 2'b00) ? c_ORD1 : bus.csr_flb_sdm_order;
    assign w_ord2p = w_order[1];
    assign w_ord3  = &w_order;

    // An order change only counts while already running; the first enabled
    // edge after reset/disable starts cleanly at whatever order is selected.
    assign w_restart = r_run && (w_order != r_order);

`ifdef FLB_SDM_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
    assign w_d       = r_lfsr[0];
`else
    assign w_d = 1'b0;
`endif

    assign w_s1 = {1'b0, r_acc1} + {1'b0, bus.s_os} + {{W{1'b0}}, w_d};
    assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[W-1:0]};
    assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[W-1:0]};

    // Unused stages contribute nothing, which keeps their delays at zero.
    assign w_c2 = w_s2[W] & w_ord2p;
    assign w_c3 = w_s3[W] & w_ord3;

    // y = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd), wraps cleanly in 4 bits.
    assign w_y = {3'b000, w_s1[W]} + {3'b000, w_c2} - {3'b000, r_c2_d}
               + {3'b000, w_c3} - {2'b00, r_c3_d, 1'b0} + {3'b000, r_c3_dd};

    // Level y+3 lies in 0..7; ones below that level, LSB first.
    assign w_lvl  = w_y + 4'd3;
    assign w_thrm = ~(7'h7F << w_lvl);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            r_acc1    <= '0;
            r_acc2    <= '0;
            r_acc3    <= '0;
            r_c2_d    <= 1'b0;
            r_c3_d    <= 1'b0;
            r_c3_dd   <= 1'b0;
            r_run     <= 1'b0;
            r_order   <= c_ORD1;
            r_os_bin  <= '0;
            r_os_thrm <= '0;
            r_os_vld  <= 1'b0;
        end else if (!bus.csr_flb_sdm_en || w_restart) begin
            // Disable and order change both return to zero state; only an
            // order change keeps the run flag so the next edge is a normal one.
            r_acc1    <= '0;
            r_acc2    <= '0;
            r_acc3    <= '0;
            r_c2_d    <= 1'b0;
            r_c3_d    <= 1'b0;
            r_c3_dd   <= 1'b0;
            r_run     <= bus.csr_flb_sdm_en;
            r_order   <= w_order;
            r_os_bin  <= '0;
            r_os_thrm <= '0;
            r_os_vld  <= 1'b0;
        end else begin
            r_acc1    <= w_s1[W-1:0];
            r_acc2    <= w_ord2p ? w_s2[W-1:0] : '0;
            r_acc3    <= w_ord3  ? w_s3[W-1:0] : '0;
            r_c2_d    <= w_c2;
            r_c3_d    <= w_c3;
            r_c3_dd   <= w_ord3 & r_c3_d;
            r_run     <= 1'b1;
            r_order   <= w_order;
            r_os_bin  <= w_y;
            r_os_thrm <= bus.csr_flb_sdm_thrm_en ? w_thrm : '0;
            r_os_vld  <= 1'b1;
        end
    end

`ifdef FLB_SDM_DITHER_EN
    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (!bus.csr_flb_sdm_en || w_restart) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`endif

    assign bus.os_bin  = r_os_bin;
    assign bus.os_thrm = r_os_thrm;
    assign bus.os_vld  = r_os_vld;

endmodule
`default_nettype wire

// File: tb/tb_flb_sdm_mash.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_flb_sdm_mash
// Purpose  : Self-checking bench for flb_sdm_mash. An integer-arithmetic
//            reference of the MASH 1-1-1 modulator predicts every output;
//            directed phases pin known sequences, then random stimulus runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flb_sdm_mash;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic nsh_clk   = 1'b0;
    logic nsh_rst_n = 1'b0;

    always #5 nsh_clk = ~nsh_clk;

    flb_sdm_mash_if #(.W(W)) bif ();

    flb_sdm_mash #(.W(W)) dut (
        .nsh_clk   (nsh_clk),
        .nsh_rst_n (nsh_rst_n),
        .bus       (bif)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int therm(input int y);
        return (1 << (y + 3)) - 1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: accumulators as integers modulo 2^W, carries as
    // integer overflow counts, noise-shaping by explicit difference terms.
    // ------------------------------------------------------------------
    int m_a1, m_a2, m_a3, m_c2p, m_c3p, m_c3pp, m_order;
    bit m_run  = 1'b0;
    int e_bin  = 0;
    int e_thrm = 0;
    bit e_vld  = 1'b0;
    bit e_zero = 1'b1;   // every output must read zero
`ifdef FLB_SDM_DITHER_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    task automatic model_clear();
        m_a1 = 0; m_a2 = 0; m_a3 = 0;
        m_c2p = 0; m_c3p = 0; m_c3pp = 0;
`ifdef FLB_SDM_DITHER_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    task automatic model_step();
        int ord, t, c1, c2, c3, y, d;
        ord = (bif.csr_flb_sdm_order == 2'b00) ? 1 : int'(bif.csr_flb_sdm_order);
        if (!bif.csr_flb_sdm_en) begin
            model_clear();
            m_run = 0; e_vld = 0; e_bin = 0; e_thrm = 0; e_zero = 1;
        end else if (m_run && ord != m_order) begin
            model_clear();
            m_order = ord; e_vld = 0; e_bin = 0; e_thrm = 0; e_zero = 0;
        end else begin
            d = 0;
`ifdef FLB_SDM_DITHER_EN
            d = int'(m_lfsr[0]);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
`endif
            t = m_a1 + int'(bif.s_os) + d; c1 = t / N; m_a1 = t % N;
            c2 = 0; c3 = 0;
            if (ord >= 2) begin t = m_a2 + m_a1; c2 = t / N; m_a2 = t % N; end
            if (ord == 3) begin t = m_a3 + m_a2; c3 = t / N; m_a3 = t % N; end
            y = c1 + (c2 - m_c2p) + (c3 - 2 * m_c3p + m_c3pp);
            m_c3pp = m_c3p; m_c3p = c3; m_c2p = c2;
            m_run = 1; m_order = ord;
            e_vld = 1; e_bin = y; e_zero = 0;
            e_thrm = bif.csr_flb_sdm_thrm_en ? therm(y) : 0;
        end
    endtask

    always @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            model_clear();
            m_run = 0; e_vld = 0; e_bin = 0; e_thrm = 0; e_zero = 1;
        end else begin
            model_step();
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge nsh_clk) begin
        if (chk_on) begin
            chk("m_vld", int'(bif.os_vld), int'(e_vld));
            if (e_vld) begin
                chk("m_bin", int'($signed(bif.os_bin)), e_bin);
                chk("m_thrm", int'(bif.os_thrm), e_thrm);
            end else if (e_zero) begin
                chk("m_bin_zero", int'($signed(bif.os_bin)), 0);
                chk("m_thrm_zero", int'(bif.os_thrm), 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic sync();           // move to just after the next edge
        @(posedge nsh_clk);
        #2;
    endtask

    task automatic sample();         // result of the next edge
        @(posedge nsh_clk);
        @(negedge nsh_clk);
    endtask

    int pat1[4] = '{0, 0, 0, 1};     // order 1, s_os = 64
    int pat3[4] = '{0, 2, -1, 1};    // order 3, s_os = 128

    task automatic run_sum(input string tag, input int lo, input int hi);
        int sum, nbad, y;
        sum = 0; nbad = 0;
        for (int i = 0; i < N; i++) begin
            sample();
            y = int'($signed(bif.os_bin));
            sum += y;
            if (y < lo || y > hi || bif.os_vld !== 1'b1) nbad++;
        end
        chk({tag, "_sum"}, sum, 128);
        chk({tag, "_range"}, nbad, 0);
    endtask

    initial begin
        bif.s_os                = '0;
        bif.csr_flb_sdm_en      = 1'b0;
        bif.csr_flb_sdm_order   = 2'b01;
        bif.csr_flb_sdm_thrm_en = 1'b1;
        nsh_rst_n               = 1'b0;

        repeat (2) @(posedge nsh_clk);
        #1;
        chk("rst_vld",  int'(bif.os_vld), 0);
        chk("rst_bin",  int'(bif.os_bin), 0);
        chk("rst_thrm", int'(bif.os_thrm), 0);

        // Order 1, s_os = 64: 0,0,0,1 repeating from the first valid sample.
        sync();
        nsh_rst_n = 1'b1;
        chk_on    = 1'b1;
        bif.csr_flb_sdm_en    = 1'b1;
        bif.csr_flb_sdm_order = 2'b01;
        bif.s_os              = 8'd64;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("o1_vld", int'(bif.os_vld), 1);
            chk("o1_seq", int'($signed(bif.os_bin)), pat1[i % 4]);
        end

        // Order 2, s_os = 0: one invalid cycle, then y = 0, thermometer 0000111.
        sync();
        bif.csr_flb_sdm_order = 2'b10;
        bif.s_os              = 8'd0;
        sample();
        chk("chg12_vld", int'(bif.os_vld), 0);
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("o2z_bin",  int'($signed(bif.os_bin)), 0);
            chk("o2z_thrm", int'(bif.os_thrm), 7);
        end

        // Fresh order-3 start, s_os = 128, over 2^W samples.
        sync();
        bif.csr_flb_sdm_en = 1'b0;
        sync();
        bif.csr_flb_sdm_en    = 1'b1;
        bif.csr_flb_sdm_order = 2'b11;
        bif.s_os              = 8'd128;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("o3_fresh", int'($signed(bif.os_bin)), pat3[i % 4]);
        end
        run_sum("o3", -3, 4);

        // Fresh order-2 start, s_os = 128.
        sync();
        bif.csr_flb_sdm_en = 1'b0;
        sync();
        bif.csr_flb_sdm_en    = 1'b1;
        bif.csr_flb_sdm_order = 2'b10;
        run_sum("o2", -1, 2);

        // Switch 2 -> 3 while running: one invalid cycle then a fresh start.
        sync();
        bif.csr_flb_sdm_order = 2'b11;
        sample();
        chk("chg23_vld", int'(bif.os_vld), 0);
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("chg23_vld1", int'(bif.os_vld), 1);
            chk("chg23_seq", int'($signed(bif.os_bin)), pat3[i % 4]);
        end

        // Asynchronous reset mid-cycle during order-3 operation.
        @(posedge nsh_clk);
        #3;
        nsh_rst_n = 1'b0;
        #1;
        chk("arst_vld",  int'(bif.os_vld), 0);
        chk("arst_bin",  int'(bif.os_bin), 0);
        chk("arst_thrm", int'(bif.os_thrm), 0);
        sync();
        nsh_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("arst_seq", int'($signed(bif.os_bin)), pat3[i % 4]);
        end

        // Thermometer disable: os_thrm zero, os_bin keeps the sequence.
        sync();
        bif.csr_flb_sdm_thrm_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("thoff_thrm", int'(bif.os_thrm), 0);
        end
        sync();
        bif.csr_flb_sdm_thrm_en = 1'b1;
        repeat (4) sample();

        // Randomised run with occasional order changes, disables, toggles.
        for (int i = 0; i < 3000; i++) begin
            sync();
            bif.s_os = W'($urandom_range(0, N - 1));
            if ($urandom_range(0, 39) == 0)
                bif.csr_flb_sdm_order = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0)
                bif.csr_flb_sdm_en = ~bif.csr_flb_sdm_en;
            else if (!bif.csr_flb_sdm_en && $urandom_range(0, 3) == 0)
                bif.csr_flb_sdm_en = 1'b1;
            if ($urandom_range(0, 15) == 0)
                bif.csr_flb_sdm_thrm_en = ~bif.csr_flb_sdm_thrm_en;
        end
        sample();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/flb_sdm_mash.md
# flb_sdm_mash

Parametrised MASH 1-1-1 sigma-delta modulator for the FLB fractional path, and the successor of the fixed 8-bit SDM. It converts a W-bit unsigned fractional offset into a multi-level integer sequence whose long-term mean equals s_os/2^W, with run-time order 1/2/3. It presents the result as a signed binary code and as an optional thermometer code for the divider and DAC consumers on the nsh_clk domain.

## Interface
- W, 8: width of s_os and of each accumulator (4..24).
- nsh_clk input 1: clock; all state updates on the rising edge.
- nsh_rst_n input 1: asynchronous active-low reset.
- s_os input W: unsigned fractional input, sampled every enabled edge.
- csr_flb_sdm_en input 1: run enable; low synchronously clears all state.
- csr_flb_sdm_order input 2: 01 = order 1, 10 = order 2, 11 = order 3, 00 = treated as order 1.
- csr_flb_sdm_thrm_en input 1: thermometer output enable.
- os_bin output 4: signed two's-complement modulator output y, range −3..+4.
- os_thrm output 7: thermometer code of y+3 (LSB-first ones); all zeros when disabled.
- os_vld output 1: high when os_bin/os_thrm carry a valid modulator sample.

## Operation
- State: acc1, acc2, acc3 (W bits each); carry delays c2_d, c3_d, c3_dd; registered outputs.
- Per enabled edge (all sums W+1 bits, carry = bit W, accumulators keep bits W−1:0):
  - s1 = acc1 + s_os, c1 = s1[W].
  - s2 = acc2 + s1[W−1:0], c2 = s2[W].
  - s3 = acc3 + s2[W−1:0], c3 = s3[W].
- Output y by order:
  - Order 1: y = c1; acc2, acc3 and the carry delays are held at 0.
  - Order 2: y = c1 + c2 − c2_d; acc3 and the c3 delays are held at 0.
  - Order 3: y = c1 + c2 − c2_d + c3 − 2·c3_d + c3_dd.
- Arithmetic and bounds:
  - y is computed in 4-bit signed arithmetic.
  - Order 1 range is 0..1, order 2 is −1..2, order 3 is −3..4. No saturation is needed.
- Thermometer:
  - os_thrm[i] = 1 for i < y+3 when csr_flb_sdm_thrm_en = 1, else 7'b0.
  - Example: y = −3 → 0000000; y = +4 → 1111111.
- Order change while enabled: at that edge all accumulators and delays clear to 0. The new order starts from zero state on the next edge, and os_vld drops for exactly that one cycle.
- Disable (csr_flb_sdm_en = 0 at an edge): all state, os_bin, os_thrm and os_vld are set to 0. Re-enable restarts from zero state.
- Mean property: over 2^W consecutive valid outputs with constant input and no dither, sum(y) = s_os exactly for every order.

## Timing
- Reset values (nsh_rst_n low, asynchronous): acc1..3 = 0, delays = 0, os_bin = 0, os_thrm = 0, os_vld = 0.
- Reset release is synchronised to the next rising edge; no output changes on the release edge itself.
- Latency is 1 cycle. The output after edge k reflects s_os sampled at edge k and the state before edge k.
- First enabled edge: os_vld = 1 after this edge. os_bin uses zero accumulator and delay state.
- s_os may change every cycle and takes effect at the next sampling edge.
- Simultaneous events, in priority order:
  1. nsh_rst_n
  2. csr_flb_sdm_en low
  3. order change
  4. normal update
- Reset mid-operation clears state immediately; operation resumes from zero state as in the first enabled edge.
- csr_flb_sdm_thrm_en is applied at the output register: a change is visible one cycle later and does not affect the modulator state.

## Configuration
- FLB_SDM_DITHER_EN defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 16'hACE1 at reset, disable and order change).
  - The LFSR LSB is added to the LSB of s1's addend (s1 = acc1 + s_os + d). This whitens order-1/2 idle tones.
  - The exact-mean property becomes mean within ±1/2^W.
- Undefined: no LFSR is present, d = 0, and behaviour is exactly as described above.

## Test plan
- Order 1, W=8, s_os=64, no dither → os_bin repeats 0,0,0,1 from the first valid sample; os_vld = 1 from edge 1.
- Order 2, s_os=0 → os_bin = 0 and os_thrm = 0000111 (thermometer enabled) on every cycle.
- Order 3, s_os=128, 256 valid samples → sum(os_bin) = 128 and every sample lies in −3..4. Order-2 run gives sum 128 and range −1..2.
- Order switched 2→3 mid-run → one cycle with os_vld = 0, then the output sequence is identical to a fresh order-3 start.
- nsh_rst_n pulsed low mid-cycle during order-3 operation → outputs are 0 immediately (no clock needed); the restart sequence matches the first-enable sequence.
- csr_flb_sdm_thrm_en = 0 → os_thrm = 0 while os_bin is unchanged. Re-enable → os_thrm = thermometer(y+3) one cycle later.
